sgd_a_rd_cmd_gen: RTL and testbench

- Generates memory read commands that stream the training dataset (A matrix) out of host/DRAM memory for the SGD engines, repeating once per epoch.
- Sits directly upstream of the memory read data mover. It drives an axis_mem_cmd-style master channel: valid, ready, 64-bit address, 32-bit length.
- Splits the dataset into bursts that never cross a MAX_BURST_BYTES-aligned boundary.
- Throttles itself by counting outstanding commands; the count is retired by a per-command data-complete pulse from the read data path.

---
 rtl/sgd_a_rd_cmd_gen.sv | 129 ++++++++++++
 tb/tb_sgd_a_rd_cmd_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_a_rd_cmd_gen.sv
// sgd_a_rd_cmd_gen: per-epoch dataset read command generator, page-split bursts, credit-throttled by rd_done.
// Optional stall_cycles/credit_stall counters under `define SGD_RD_CMD_PERF_EN.
module sgd_a_rd_cmd_gen #(
    parameter int MAX_BURST_BYTES = 4096,
    parameter int MAX_OUTSTANDING = 16,
    parameter int OUT_CNT_WIDTH   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] base_addr,
    input  logic [31:0] total_bytes,
    input  logic [31:0] num_epochs,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [63:0] cmd_address,
    output logic [31:0] cmd_length,
    input  logic        rd_done,
    output logic        busy,
    output logic        done,
    output logic [31:0] epoch_cnt,
`ifdef SGD_RD_CMD_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] credit_stall,
`endif
    output logic        err
);
    localparam int LB = $clog2(MAX_BURST_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t state, state_nx;
    logic [63:0] base, ptr;
    logic [31:0] total, epochs, rem, room, len;
    logic [OUT_CNT_WIDTH-1:0] out_cnt;
    logic hs, last, more, credit;

    assign hs     = cmd_valid && cmd_ready;
    assign room   = 32'(MAX_BURST_BYTES) - 32'(ptr[LB-1:0]);
    assign len    = rem < room ? rem : room;
    assign last   = hs && rem == cmd_length;
    assign more   = epoch_cnt + 32'd1 < epochs;
    assign credit = out_cnt < OUT_CNT_WIDTH'(MAX_OUTSTANDING);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (total_bytes == '0 || num_epochs == '0) ? DONE : ISSUE;
            ISSUE:   if (last && !more) state_nx = DRAIN;
            DRAIN:   if (out_cnt == '0) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base        <= '0;
            ptr         <= '0;
            total       <= '0;
            epochs      <= '0;
            rem         <= '0;
            cmd_valid   <= 1'b0;
            cmd_address <= '0;
            cmd_length  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            epoch_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base      <= base_addr;
                    total     <= total_bytes;
                    epochs    <= num_epochs;
                    ptr       <= base_addr;
                    rem       <= total_bytes;
                    busy      <= 1'b1;
                    epoch_cnt <= '0;
                end
                ISSUE: if (hs) begin
                    // the last burst of an epoch rewinds to the dataset start when epochs remain
                    cmd_valid <= 1'b0;
                    ptr       <= last && more ? base : ptr + 64'(cmd_length);
                    rem       <= last && more ? total : rem - cmd_length;
                    if (last) epoch_cnt <= epoch_cnt + 32'd1;
                end else if (!cmd_valid && credit) begin
                    cmd_valid   <= 1'b1;
                    cmd_address <= ptr;
                    cmd_length  <= len;
                end
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // a retirement with nothing outstanding is a protocol error and leaves the count at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
            err     <= 1'b0;
        end else if (hs && !rd_done) begin
            out_cnt <= out_cnt + OUT_CNT_WIDTH'(1);
        end else if (!hs && rd_done) begin
            if (out_cnt == '0) err <= 1'b1;
            else out_cnt <= out_cnt - OUT_CNT_WIDTH'(1);
        end
    end

`ifdef SGD_RD_CMD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            stall_cycles <= '0;
            credit_stall <= '0;
        end else begin
            if (cmd_valid && !cmd_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (state == ISSUE && !cmd_valid && !credit && credit_stall != '1) credit_stall <= credit_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sgd_a_rd_cmd_gen.sv
// tb_sgd_a_rd_cmd_gen: directed plus randomized jobs checked against a burst-list reference model.
module tb_sgd_a_rd_cmd_gen;
    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
        bit          last;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, cmd_ready = 1'b0, rd_done = 1'b0;
    logic [63:0] base_addr = '0;
    logic [31:0] total_bytes = '0, num_epochs = '0;
    logic        cmd_valid, busy, done, err;
    logic [63:0] cmd_address;
    logic [31:0] cmd_length, epoch_cnt;
`ifdef SGD_RD_CMD_PERF_EN
    logic [31:0] stall_cycles, credit_stall;
`endif

    cmd_t        exp_q[$];
    int          owed = 0, exp_ep = 0, hs_cnt = 0;
    bit          prev_stall = 0, fin;
    logic [63:0] pa;
    logic [31:0] pl;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    sgd_a_rd_cmd_gen dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .total_bytes(total_bytes), .num_epochs(num_epochs),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_address(cmd_address),
        .cmd_length(cmd_length), .rd_done(rd_done), .busy(busy), .done(done),
        .epoch_cnt(epoch_cnt),
`ifdef SGD_RD_CMD_PERF_EN
        .stall_cycles(stall_cycles), .credit_stall(credit_stall),
`endif
        .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_addr"}, cmd_address, 0);
        chk({tag, "_len"}, cmd_length, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_epoch"}, epoch_cnt, 0);
        chk({tag, "_err"}, err, 0);
`ifdef SGD_RD_CMD_PERF_EN
        chk({tag, "_stall"}, stall_cycles, 0);
        chk({tag, "_credit"}, credit_stall, 0);
`endif
    endtask

    // Reference: every epoch walks the dataset in bursts that stop at each 4 KiB boundary
    task automatic build(input logic [63:0] b, input logic [31:0] t, input logic [31:0] e);
        logic [63:0] a, l;
        logic [31:0] r;
        exp_q.delete();
        for (int k = 0; k < int'(e); k++) begin
            a = b;
            r = t;
            while (r != 0) begin
                l = 64'd4096 - (a % 64'd4096);
                if (l > 64'(r)) l = 64'(r);
                exp_q.push_back('{a, l[31:0], l == 64'(r)});
                a += l;
                r -= l[31:0];
            end
        end
    endtask

    task automatic job_start(input logic [63:0] b, input logic [31:0] t, input logic [31:0] e);
        build(b, t, e);
        exp_ep = 0;
        hs_cnt = 0;
        prev_stall = 0;
        @(negedge clk);
        start = 1; base_addr = b; total_bytes = t; num_epochs = e;
        cmd_ready = 0; rd_done = 0;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
        chk("epoch_cleared", epoch_cnt, 0);
    endtask

    task automatic drive(input int max_cyc, input int rdy_pct, input int done_pct, output bit f);
        f = 0;
        for (int c = 0; c < max_cyc && !f; c++) begin
            chk("epoch_cnt", epoch_cnt, 64'(exp_ep));
            if (prev_stall) begin
                chk("hold_valid", cmd_valid, 1);
                chk("hold_addr", cmd_address, pa);
                chk("hold_len", cmd_length, pl);
            end
            if (done) begin
                f = 1;
                chk("done_cmds_left", 64'(exp_q.size()), 0);
                chk("done_owed", 64'(owed), 0);
                chk("done_busy", busy, 0);
            end else begin
                chk("busy", busy, 1);
                cmd_ready = $urandom_range(99) < rdy_pct;
                rd_done = 0;
                if (owed > 0 && $urandom_range(99) < done_pct) begin
                    rd_done = 1;
                    owed--;
                end
                if (cmd_valid && cmd_ready) begin
                    chk("cmd_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        chk("cmd_addr", cmd_address, exp_q[0].addr);
                        chk("cmd_len", cmd_length, exp_q[0].len);
                        if (exp_q[0].last) exp_ep++;
                        void'(exp_q.pop_front());
                    end
                    owed++;
                    hs_cnt++;
                    chk("outstanding_max", owed <= 16, 1);
                end
                prev_stall = cmd_valid && !cmd_ready;
                pa = cmd_address;
                pl = cmd_length;
                @(negedge clk);
            end
        end
        cmd_ready = 0;
        rd_done = 0;
    endtask

    task automatic job_end(input int max_cyc, input int rdy_pct, input int done_pct);
        bit f;
        drive(max_cyc, rdy_pct, done_pct, f);
        chk("done_seen", f, 1);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", cmd_valid, 0);
        chk("no_err", err, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        chk_zero("reset");

        job_start(64'h1000, 8192, 1);
        job_end(200, 100, 100);
        chk("tp1_epoch", epoch_cnt, 1);

        job_start(64'h0F80, 256, 2);
        job_end(200, 100, 100);
        chk("tp2_epoch", epoch_cnt, 2);

        // empty dataset: straight to completion
        @(negedge clk);
        start = 1; base_addr = 64'h40; total_bytes = 0; num_epochs = 5;
        @(negedge clk);
        start = 0;
        chk("zero_busy", busy, 1);
        chk("zero_done_early", done, 0);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy_fall", busy, 0);
        chk("zero_epoch", epoch_cnt, 0);
        chk("zero_valid", cmd_valid, 0);
        @(negedge clk);
        chk("zero_done_once", done, 0);

        job_start(64'h100, 640, 0);
        job_end(50, 100, 100);

        // credit limit with rd_done withheld
        job_start(64'h0, 64 * 4096, 1);
        drive(60, 100, 0, fin);
        chk("credit_16", 64'(hs_cnt), 16);
        chk("credit_valid_low", cmd_valid, 0);
`ifdef SGD_RD_CMD_PERF_EN
        chk("credit_stall_nz", credit_stall != 0, 1);
`endif
        start = 1; base_addr = 64'hDEAD_0000; total_bytes = 64; num_epochs = 1;
        @(negedge clk);
        start = 0;
        chk("start_ignored_busy", busy, 1);
        chk("start_ignored_valid", cmd_valid, 0);
        for (int i = 1; i <= 2; i++) begin
            rd_done = 1;
            owed--;
            @(negedge clk);
            rd_done = 0;
            drive(10, 100, 0, fin);
            chk("credit_release", 64'(hs_cnt), 64'(16 + i));
        end
        job_end(3000, 100, 100);

        for (int j = 0; j < 6; j++) begin
            logic [63:0] b;
            logic [31:0] t, e;
            b = {$urandom, $urandom} & ~64'h3F;
            t = $urandom_range(0, 400) * 64;
            e = $urandom_range(1, 3);
            if (j == 0) begin
                b = 64'hFFFF_FFFF_FFFF_FE40;
                t = 1024;
            end
            job_start(b, t, e);
            job_end(6000, $urandom_range(30, 100), $urandom_range(20, 100));
        end

        // ready withheld for 10 cycles with a command pending
        job_start(64'h40, 4096, 1);
        @(negedge clk);
        chk("stall_valid", cmd_valid, 1);
        chk("stall_addr0", cmd_address, 64'h40);
        chk("stall_len0", cmd_length, 4032);
        repeat (10) begin
            @(negedge clk);
            chk("stall_hold_valid", cmd_valid, 1);
            chk("stall_hold_addr", cmd_address, 64'h40);
            chk("stall_hold_len", cmd_length, 4032);
        end
`ifdef SGD_RD_CMD_PERF_EN
        chk("stall_cycles", stall_cycles, 10);
`endif
        job_end(200, 100, 100);

        // reset mid-job, then a stray rd_done in idle
        job_start(64'h0, 32768, 1);
        drive(8, 100, 0, fin);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_zero("midrst");
        owed = 0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_idle", cmd_valid, 0);
        rd_done = 1;
        @(negedge clk);
        rd_done = 0;
        chk("err_set", err, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_zero("err_rst");

        job_start(64'h2000, 512, 1);
        job_end(500, 80, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
